// File: rtl/pe_pkg.sv
// Shared constants, FSM encoding and the index-to-vector reference mapping for
// the 12-wide priority decoder and its matching encoder.
package pe_pkg;

   localparam int WIDTH   = 12;
   localparam int IDX_W   = 4;
   localparam int IDX_MAX = 12;

   typedef enum logic [1:0] {
      IDLE,
      PAR,
      SER
   } dec_state_t;

   // Returns {err, vec}. Index 12 aliases bit 11, matching the encoder's output coding.
   function automatic logic [WIDTH:0] dec_vec(input logic [IDX_W-1:0] idx, input logic therm);
      logic [WIDTH-1:0] onehot;
      logic [IDX_W-1:0] sel;
      onehot = '0;
      sel    = '0;
      if (int'(idx) > IDX_MAX) begin
         return {1'b1, {WIDTH{1'b0}}};
      end
      sel = (int'(idx) == IDX_MAX) ? IDX_W'(WIDTH - 1) : idx;
      onehot[sel] = 1'b1;
      return {1'b0, therm ? ((onehot << 1) - WIDTH'(1)) : onehot};
   endfunction

endpackage

// File: rtl/unary_ser_12.sv
// Holds the decoded vector and serialises it LSB-first as a 12-cycle
// temporal-unary stream while en_i is high.
module unary_ser_12
   import pe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] vec_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] vec_o,
   output logic             ser_bit_o,
   output logic             ser_last_o
);

   localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

   logic [WIDTH-1:0] vec_q;
   logic [3:0]       cnt_q, cnt_d;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      if (!rst_n) begin
         vec_q <= '0;
         cnt_q <= '0;
      end else begin
         if (load_i) vec_q <= vec_i;
         cnt_q <= cnt_d;
      end
   end

   assign vec_o      = vec_q;
   assign ser_bit_o  = en_i & vec_q[cnt_q];
   assign ser_last_o = en_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/priority_dec_12.sv
// 4-bit index to 12-bit one-hot/thermometer decoder with a valid/ready input,
// a held parallel output and a 12-cycle serial output.
module priority_dec_12
   import pe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_therm,
   input  logic             in_ser,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_vec,
   output logic             out_err,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_last
);

   dec_state_t     state_q, state_d;
   logic           err_q;
   logic           xfer;
   logic           ready_st;
   logic [WIDTH:0] dec;
   dec_state_t     next_mode;

   assign dec       = dec_vec(in_idx, in_therm);
   assign xfer      = in_valid & in_ready;
   assign next_mode = in_ser ? SER : PAR;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (xfer) err_q <= dec[WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (xfer) state_d = next_mode;
         PAR:     if (out_ready) state_d = xfer ? next_mode : IDLE;
         SER:     if (ser_last) state_d = xfer ? next_mode : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_st  = 1'b0;
      out_valid = 1'b0;
      ser_valid = 1'b0;
      unique case (state_q)
         IDLE:    ready_st = 1'b1;
         PAR: begin
            ready_st  = out_ready;
            out_valid = 1'b1;
         end
         SER: begin
            ready_st  = ser_last;
            ser_valid = 1'b1;
         end
         default: ready_st = 1'b0;
      endcase
   end

   // Held low while reset is asserted so nothing is accepted mid-reset.
   assign in_ready = rst_n & ready_st;
   assign out_err  = err_q;

   unary_ser_12 u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (xfer),
      .vec_i      (dec[WIDTH-1:0]),
      .en_i       (ser_valid),
      .vec_o      (out_vec),
      .ser_bit_o  (ser_bit),
      .ser_last_o (ser_last)
   );

endmodule

// File: tb/tb_priority_dec_12.sv
// Directed and light random checks of priority_dec_12: parallel/serial modes,
// stalls, illegal indices, reset abort and encoder round-trip.
module tb_priority_dec_12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_idx;
   logic        in_therm;
   logic        in_ser;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_vec;
   logic        out_err;
   logic        ser_bit;
   logic        ser_valid;
   logic        ser_last;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [11:0] OH_EXP [13] = '{
      12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040,
      12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h800
   };

   priority_dec_12 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .in_therm  (in_therm),
      .in_ser    (in_ser),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_err   (out_err),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .ser_last  (ser_last)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: {err, vec} built bit by bit.
   function automatic logic [12:0] ref_dec(input logic [3:0] idx, input logic therm);
      logic [11:0] v;
      int          sel;
      v = '0;
      if (idx > 4'd12) return {1'b1, 12'h000};
      sel = (idx == 4'd12) ? 11 : int'(idx);
      for (int b = 0; b < 12; b++) v[b] = therm ? (b <= sel) : (b == sel);
      return {1'b0, v};
   endfunction

   // Leading-one encoder; bit 11 reports index 12.
   function automatic int enc(input logic [11:0] v);
      int b;
      b = -1;
      for (int i = 0; i < 12; i++) if (v[i]) b = i;
      return (b == 11) ? 12 : b;
   endfunction

   task automatic ser_stream(input string tag, input logic [11:0] exp, input logic exp_err,
                             input logic chain, input logic [3:0] c_idx, input logic c_therm);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("%s ser_valid[%0d]", tag, k), ser_valid, 1);
         check($sformatf("%s ser_bit[%0d]", tag, k), ser_bit, exp[k]);
         check($sformatf("%s ser_last[%0d]", tag, k), ser_last, (k == 11));
         check($sformatf("%s err[%0d]", tag, k), out_err, exp_err);
         check($sformatf("%s out_valid[%0d]", tag, k), out_valid, 0);
         if (k == 10) check($sformatf("%s in_ready[10]", tag), in_ready, 0);
         if (k == 11) begin
            check($sformatf("%s in_ready[11]", tag), in_ready, 1);
            in_valid = chain;
            in_idx   = c_idx;
            in_therm = c_therm;
            in_ser   = 1'b1;
         end
         tick();
      end
   endtask

   initial begin
      logic [12:0] exp;
      logic [3:0]  r_idx;
      logic        r_therm, r_ser;
      int          stall;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_idx    = '0;
      in_therm  = 1'b0;
      in_ser    = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst ser_valid", ser_valid, 0);
      check("rst out_vec", out_vec, 0);
      check("rst out_err", out_err, 0);
      check("rst ser_bit", ser_bit, 0);
      check("rst ser_last", ser_last, 0);
      rst_n = 1'b1;
      #1;
      check("post-rst in_ready", in_ready, 1);

      // Parallel one-hot sweep, one result per cycle
      out_ready = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         in_valid = 1'b1;
         in_idx   = 4'(i);
         in_therm = 1'b0;
         in_ser   = 1'b0;
         tick();
         @(negedge clk);
         check($sformatf("sweep valid[%0d]", i), out_valid, 1);
         check($sformatf("sweep vec[%0d]", i), out_vec, OH_EXP[i]);
         check($sformatf("sweep err[%0d]", i), out_err, 0);
      end
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("sweep idle", out_valid, 0);

      // Thermometer idx 5 with a 3-cycle stall
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_idx    = 4'd5;
      in_therm  = 1'b1;
      in_ser    = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s == 3) out_ready = 1'b1;
         @(negedge clk);
         check($sformatf("stall valid[%0d]", s), out_valid, 1);
         check($sformatf("stall vec[%0d]", s), out_vec, 12'h03F);
         check($sformatf("stall in_ready[%0d]", s), in_ready, (s == 3));
         tick();
      end
      @(negedge clk);
      check("stall idle", out_valid, 0);

      // Serial thermometer idx 3, chained into serial one-hot idx 0
      in_valid = 1'b1;
      in_idx   = 4'd3;
      in_therm = 1'b1;
      in_ser   = 1'b1;
      tick();
      in_valid = 1'b0;
      ser_stream("ser3", 12'h00F, 1'b0, 1'b1, 4'd0, 1'b0);
      in_valid = 1'b0;
      ser_stream("ser0", 12'h001, 1'b0, 1'b0, 4'd0, 1'b0);
      @(negedge clk);
      check("ser idle", ser_valid, 0);

      // Illegal index, both modes
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_idx    = 4'd14;
      in_therm  = 1'b0;
      in_ser    = 1'b0;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("ill par valid", out_valid, 1);
      check("ill par vec", out_vec, 0);
      check("ill par err", out_err, 1);
      tick();
      in_valid = 1'b1;
      in_ser   = 1'b1;
      tick();
      in_valid = 1'b0;
      ser_stream("ill ser", 12'h000, 1'b1, 1'b0, 4'd0, 1'b0);

      // Reset during serial bit 6
      in_valid = 1'b1;
      in_idx   = 4'd11;
      in_therm = 1'b1;
      in_ser   = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("pre-abort bit[%0d]", k), ser_bit, 1);
         tick();
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("abort in_ready low", in_ready, 0);
      tick();
      @(negedge clk);
      check("abort ser_valid", ser_valid, 0);
      check("abort ser_bit", ser_bit, 0);
      check("abort ser_last", ser_last, 0);
      check("abort out_valid", out_valid, 0);
      check("abort out_vec", out_vec, 0);
      check("abort out_err", out_err, 0);
      check("abort in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("abort in_ready rel", in_ready, 1);
      in_valid  = 1'b1;
      in_idx    = 4'd0;
      in_therm  = 1'b0;
      in_ser    = 1'b0;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("after abort valid", out_valid, 1);
      check("after abort vec", out_vec, 12'h001);
      tick();

      // Random mix of modes and stalls
      for (int t = 0; t < 30; t++) begin
         r_idx   = 4'($urandom_range(0, 15));
         r_therm = 1'($urandom_range(0, 1));
         r_ser   = 1'($urandom_range(0, 1));
         stall   = $urandom_range(0, 2);
         exp     = ref_dec(r_idx, r_therm);
         in_valid  = 1'b1;
         in_idx    = r_idx;
         in_therm  = r_therm;
         in_ser    = r_ser;
         out_ready = 1'b0;
         tick();
         in_valid = 1'b0;
         if (r_ser) begin
            ser_stream($sformatf("rnd%0d", t), exp[11:0], exp[12], 1'b0, 4'd0, 1'b0);
         end else begin
            for (int s = 0; s <= stall; s++) begin
               out_ready = (s == stall);
               @(negedge clk);
               check($sformatf("rnd%0d valid", t), out_valid, 1);
               check($sformatf("rnd%0d vec", t), out_vec, exp[11:0]);
               check($sformatf("rnd%0d err", t), out_err, exp[12]);
               if (!r_therm && r_idx <= 4'd12 && r_idx != 4'd11)
                  check($sformatf("rnd%0d roundtrip", t), enc(out_vec), r_idx);
               tick();
            end
         end
         @(negedge clk);
         check($sformatf("rnd%0d idle", t), out_valid | ser_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
